// File: rtl/counter_bank_pkg.sv
// Shared constants and helpers for the counter_bank event counter slice.
package counter_bank_pkg;

  localparam int unsigned RD_WORD_W = 32;

  typedef logic [RD_WORD_W-1:0] rd_word_t;

  localparam rd_word_t RD_OOR_VALUE = '0;

  function automatic int unsigned words_per_cnt(input int unsigned width);
    return width / RD_WORD_W;
  endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Snapshot read bus: channel/word select in, registered 32-bit word out.
interface counter_bank_if
  import counter_bank_pkg::*;
#(
  parameter int unsigned CH_BITS   = 3,
  parameter int unsigned WORD_BITS = 1
);

  logic [CH_BITS-1:0]   i_rd_ch;
  logic [WORD_BITS-1:0] i_rd_word;
  rd_word_t             o_rd_data;

  modport master (
    output i_rd_ch,
    output i_rd_word,
    input  o_rd_data
  );

  modport slave (
    input  i_rd_ch,
    input  i_rd_word,
    output o_rd_data
  );

endinterface

// File: rtl/counter_bank_ch.sv
// One counter channel: live count, snapshot copy and sticky wrap flag.
// COUNTER_BANK_SATURATE_EN makes the count stop at all-ones instead of wrapping.
module counter_bank_ch #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             clear_i,
  input  logic             snapshot_i,
  output logic [WIDTH-1:0] snap_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    cnt_d  = cnt_q;
    snap_d = snap_q;
    wrap_d = wrap_q;
    if (clear_i) begin
      cnt_d  = '0;
      snap_d = '0;
      wrap_d = 1'b0;
    end else begin
      // Snapshot takes the pre-increment value so all channels copy the same edge.
      if (snapshot_i) begin
        snap_d = cnt_q;
      end
      if (inc_i) begin
        if (&cnt_q) begin
`ifdef COUNTER_BANK_SATURATE_EN
          cnt_d = cnt_q;
`else
          cnt_d = '0;
`endif
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      snap_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
      wrap_q <= wrap_d;
    end
  end

  assign snap_o = snap_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/counter_bank.sv
// Multi-channel event counter bank with atomic snapshot and 32-bit read port.
// Optional build macro: COUNTER_BANK_SATURATE_EN (saturating counters).
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 8,
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned WORD_BITS = (words_per_cnt(WIDTH) > 1) ? $clog2(words_per_cnt(WIDTH)) : 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NUM_CH-1:0] i_inc,
  input  logic              i_clear,
  input  logic              i_snapshot,
  counter_bank_if.slave     rd,
  output logic [NUM_CH-1:0] o_wrap
);

  localparam int unsigned NWORDS = words_per_cnt(WIDTH);

  logic [NUM_CH-1:0] inc_q;
  logic              clear_q;
  rd_word_t          rd_data_q, rd_data_d;
  logic [WIDTH-1:0]  snap [NUM_CH];
  logic [NUM_CH-1:0] wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inc_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      inc_q   <= i_inc;
      clear_q <= i_clear;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    counter_bank_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk_i      (i_clk),
      .reset_i    (i_reset),
      .inc_i      (inc_q[c]),
      .clear_i    (clear_q),
      .snapshot_i (i_snapshot),
      .snap_o     (snap[c]),
      .wrap_o     (wrap[c])
    );
  end

  // Full decode over legal channel/word pairs; anything else falls to the default.
  always_comb begin
    rd_data_d = RD_OOR_VALUE;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned w = 0; w < NWORDS; w++) begin
        if (rd.i_rd_ch == CH_BITS'(c) && rd.i_rd_word == WORD_BITS'(w)) begin
          rd_data_d = snap[c][w*RD_WORD_W +: RD_WORD_W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd.o_rd_data = rd_data_q;
  assign o_wrap       = wrap;

endmodule

// File: tb/tb_counter_bank.sv
// Directed self-checking bench: an 8ch/64-bit bank and a 6ch/32-bit bank.
module tb_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inc_a, wrap_a;
  logic       clr_a, snp_a;
  logic [5:0] inc_b, wrap_b;
  logic       clr_b, snp_b;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  logic [31:0] exp_sat;

  always #5 clk = ~clk;

  counter_bank_if #(.CH_BITS(3), .WORD_BITS(1)) rd_a ();
  counter_bank_if #(.CH_BITS(3), .WORD_BITS(1)) rd_b ();

  counter_bank #(.NUM_CH(8), .WIDTH(64)) dut_a (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_inc      (inc_a),
    .i_clear    (clr_a),
    .i_snapshot (snp_a),
    .rd         (rd_a),
    .o_wrap     (wrap_a)
  );

  counter_bank #(.NUM_CH(6), .WIDTH(32)) dut_b (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_inc      (inc_b),
    .i_clear    (clr_b),
    .i_snapshot (snp_b),
    .rd         (rd_b),
    .o_wrap     (wrap_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_rd_a(input string tag, input int ch, input int w, input logic [31:0] exp);
    rd_a.i_rd_ch   = 3'(ch);
    rd_a.i_rd_word = 1'(w);
    tick();
    check_eq(tag, {32'h0, rd_a.o_rd_data}, {32'h0, exp});
  endtask

  task automatic chk_rd_b(input string tag, input int ch, input int w, input logic [31:0] exp);
    rd_b.i_rd_ch   = 3'(ch);
    rd_b.i_rd_word = 1'(w);
    tick();
    check_eq(tag, {32'h0, rd_b.o_rd_data}, {32'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef COUNTER_BANK_SATURATE_EN
    exp_sat = 32'hFFFF_FFFF;
`else
    exp_sat = 32'h0000_0001;
`endif
    rst = 1'b1;
    inc_a = '0; clr_a = 1'b0; snp_a = 1'b0;
    inc_b = '0; clr_b = 1'b0; snp_b = 1'b0;
    rd_a.i_rd_ch = '0; rd_a.i_rd_word = '0;
    rd_b.i_rd_ch = '0; rd_b.i_rd_word = '0;
    repeat (2) tick();
    check_eq("rst_rd_a", {32'h0, rd_a.o_rd_data}, 64'h0);
    check_eq("rst_wrap_a", {56'h0, wrap_a}, 64'h0);
    check_eq("rst_wrap_b", {58'h0, wrap_b}, 64'h0);
    rst = 1'b0;
    for (int ch = 0; ch < 8; ch++)
      for (int w = 0; w < 2; w++)
        chk_rd_a($sformatf("rst_a_c%0d_w%0d", ch, w), ch, w, 32'h0);
    for (int ch = 0; ch < 6; ch++)
      chk_rd_b($sformatf("rst_b_c%0d", ch), ch, 0, 32'h0);

    // Five strobes on ch2, snapshot two cycles after the last one.
    inc_a = 8'h04;
    repeat (5) tick();
    inc_a = '0;
    tick();
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("inc_c2_w0", 2, 0, 32'd5);
    chk_rd_a("inc_c2_w1", 2, 1, 32'd0);
    chk_rd_a("inc_c0_w0", 0, 0, 32'd0);
    chk_rd_a("inc_c7_w0", 7, 0, 32'd0);

    // Snapshot one cycle after a single strobe still sees the old count.
    inc_a = 8'h10;
    tick();
    inc_a = '0;
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("lat_c4_early", 4, 0, 32'd0);
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("lat_c4_late", 4, 0, 32'd1);

    // Carry across the 32-bit word boundary.
    force dut_a.g_ch[0].u_ch.cnt_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut_a.g_ch[0].u_ch.cnt_q;
    tick();
    inc_a = 8'h01;
    tick();
    inc_a = '0;
    tick();
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("carry_w0", 0, 0, 32'h0);
    chk_rd_a("carry_w1", 0, 1, 32'h1);
    check_eq("carry_wrap_a", {56'h0, wrap_a}, 64'h0);

    // Wrap or saturate on the 32-bit bank.
    force dut_b.g_ch[1].u_ch.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut_b.g_ch[1].u_ch.cnt_q;
    tick();
    inc_b = 6'b000010;
    repeat (2) tick();
    inc_b = '0;
    tick();
    snp_b = 1'b1;
    tick();
    snp_b = 1'b0;
    chk_rd_b("wrap_c1", 1, 0, exp_sat);
    check_eq("wrap_flag_b", {58'h0, wrap_b}, 64'h2);
    chk_rd_b("oor_ch7", 7, 0, 32'h0);
    chk_rd_b("oor_ch6", 6, 0, 32'h0);
    chk_rd_b("oor_word1", 1, 1, 32'h0);
    chk_rd_b("wrap_c1_again", 1, 0, exp_sat);

    // Bring ch3 to 7, then increment and snapshot together.
    inc_a = 8'h08;
    repeat (7) tick();
    inc_a = '0;
    tick();
    inc_a = 8'h08;
    tick();
    inc_a = '0;
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("sim_snap_old", 3, 0, 32'd7);
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("sim_cnt_new", 3, 0, 32'd8);

    // Clear with simultaneous inc and snapshot on both banks.
    clr_a = 1'b1; inc_a = 8'h08; snp_a = 1'b1;
    clr_b = 1'b1; inc_b = 6'b000010; snp_b = 1'b1;
    tick();
    clr_a = 1'b0; inc_a = '0; snp_a = 1'b0;
    clr_b = 1'b0; inc_b = '0; snp_b = 1'b0;
    check_eq("clr_wrap_b_pending", {58'h0, wrap_b}, 64'h2);
    tick();
    check_eq("clr_wrap_b", {58'h0, wrap_b}, 64'h0);
    check_eq("clr_wrap_a", {56'h0, wrap_a}, 64'h0);
    chk_rd_a("clr_snap_c3", 3, 0, 32'h0);
    chk_rd_a("clr_snap_c2", 2, 0, 32'h0);
    chk_rd_b("clr_snap_b1", 1, 0, 32'h0);
    snp_a = 1'b1; snp_b = 1'b1;
    tick();
    snp_a = 1'b0; snp_b = 1'b0;
    chk_rd_a("clr_cnt_c3", 3, 0, 32'h0);
    chk_rd_a("clr_cnt_c0_w1", 0, 1, 32'h0);
    chk_rd_b("clr_cnt_b1", 1, 0, 32'h0);

    // Mid-run reset clears the read register on the next edge.
    inc_a = 8'h20;
    repeat (3) tick();
    inc_a = '0;
    tick();
    snp_a = 1'b1;
    tick();
    snp_a = 1'b0;
    chk_rd_a("midrst_pre", 5, 0, 32'd3);
    rst = 1'b1;
    tick();
    check_eq("midrst_rd", {32'h0, rd_a.o_rd_data}, 64'h0);
    rst = 1'b0;
    chk_rd_a("midrst_post", 5, 0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
